// File: rtl/data_memory_pkg.sv
// Shared bus encodings and defaults for the CPU and its data memory.
// The clear-engine state encoding lives here so both sides agree on it.
package data_memory_pkg;

    localparam logic READ_FROM_MEM = 1'b0;
    localparam logic WRITE_TO_MEM  = 1'b1;

    localparam int unsigned DEFAULT_ADDR_W = 12;
    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/mem_clear_ctrl.sv
// Sequential whole-array clear engine: sweeps addresses 0..DEPTH-1, one word per falling edge.
// Requests arriving while a sweep is running are ignored rather than restarting it.
module mem_clear_ctrl
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_mem,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    clr_state_e        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_mem) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    // The word at cnt is zeroed on this same edge by the array.
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign clr_addr = cnt;
    assign clr_we   = (state == ST_CLEAR);

endmodule

// File: rtl/data_memory.sv
// Single-port word memory answering the CPU bus, committing on the falling edge of clk.
// Also hosts a preload port (priority over CPU writes) and a sequential clear engine.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_mem,
    input  logic              init_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              busy,
    output logic              collision
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              addr_ok;
    logic              init_ok;
    logic              cpu_read;
    logic              cpu_write;
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic              collision_d;

    mem_clear_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_clear_ctrl (
        .clk      (clk),
        .reset    (reset),
        .clr_mem  (clr_mem),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    always_comb begin
        addr_ok     = 32'(address) < DEPTH;
        init_ok     = 32'(init_addr) < DEPTH;
        cpu_read    = mem_en && (read_write == READ_FROM_MEM);
        cpu_write   = mem_en && (read_write == WRITE_TO_MEM);
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        collision_d = 1'b0;
        if (clr_we) begin
            we    = 1'b1;
            waddr = clr_addr[IDX_W-1:0];
        end else if (init_en) begin
            // A preload always wins the write port, even when its own address is out of range.
            we          = init_ok;
            waddr       = init_addr[IDX_W-1:0];
            wdata       = init_data;
            collision_d = cpu_write;
        end else if (cpu_write) begin
            we    = addr_ok;
            waddr = address[IDX_W-1:0];
            wdata = wr_data;
        end
    end

    always_ff @(negedge clk) begin
        if (we && !reset) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads sample the pre-edge contents, so a same-edge preload is not visible yet.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            rd_data   <= '0;
            collision <= 1'b0;
        end else begin
            collision <= collision_d;
            if (cpu_read) begin
                rd_data <= (clr_we || !addr_ok) ? '0 : mem[address[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench: a full-size and a 16-word instance share stimulus; an array model
// predicts rd_data/busy/collision per falling edge and a monitor checks them at the next rise.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_en = 1'b0;
    logic        read_write = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] wr_data = '0;
    logic        clr_mem = 1'b0;
    logic        init_en = 1'b0;
    logic [11:0] init_addr = '0;
    logic [31:0] init_data = '0;

    logic [31:0] rd_f, rd_s;
    logic        busy_f, busy_s, coll_f, coll_s;

    always #5 clk = ~clk;

    data_memory u_full (
        .clk(clk), .reset(reset), .mem_en(mem_en), .read_write(read_write),
        .address(address), .wr_data(wr_data), .rd_data(rd_f), .clr_mem(clr_mem),
        .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .busy(busy_f), .collision(coll_f)
    );

    data_memory #(.DEPTH(16)) u_small (
        .clk(clk), .reset(reset), .mem_en(mem_en), .read_write(read_write),
        .address(address), .wr_data(wr_data), .rd_data(rd_s), .clr_mem(clr_mem),
        .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .busy(busy_s), .collision(coll_s)
    );

    // Reference model: word arrays plus "words still to clear" per instance.
    int unsigned dep [2] = '{4096, 16};
    logic [31:0] mdl [2][4096];
    int unsigned clear_left [2] = '{0, 0};
    logic [31:0] m_rd [2] = '{32'h0, 32'h0};

    typedef struct {
        int          inst;
        int          step;
        logic [31:0] rd;
        logic        busy;
        logic        coll;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int fails = 0;
    int step_no = 0;

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic c;
            c = 1'b0;
            if (reset) begin
                clear_left[k] = 0;
                m_rd[k] = '0;
            end else if (clear_left[k] > 0) begin
                mdl[k][dep[k] - clear_left[k]] = '0;
                if (mem_en && !read_write) m_rd[k] = '0;
                clear_left[k]--;
            end else begin
                c = init_en && mem_en && read_write;
                if (mem_en && !read_write)
                    m_rd[k] = (address < dep[k]) ? mdl[k][address] : 32'h0;
                if (init_en) begin
                    if (init_addr < dep[k]) mdl[k][init_addr] = init_data;
                end else if (mem_en && read_write && address < dep[k]) begin
                    mdl[k][address] = wr_data;
                end
                if (clr_mem) clear_left[k] = dep[k];
            end
            q.push_back('{k, step_no, m_rd[k], clear_left[k] > 0, c});
        end
    endtask

    // Inputs are set after a rising edge; the DUT commits on the following falling edge.
    task automatic step();
        model_edge();
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        mem_en = 0; read_write = 0; clr_mem = 0; init_en = 0;
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) begin clr_in(); step(); end
    endtask

    task automatic do_init(input logic [11:0] a, input logic [31:0] d);
        clr_in(); init_en = 1; init_addr = a; init_data = d; step();
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        clr_in(); mem_en = 1; read_write = 1; address = a; wr_data = d; step();
    endtask

    task automatic do_read(input logic [11:0] a);
        clr_in(); mem_en = 1; read_write = 0; address = a; step();
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] ard;
        logic        ab, ac;
        forever begin
            @(posedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                ard = (e.inst == 0) ? rd_f : rd_s;
                ab  = (e.inst == 0) ? busy_f : busy_s;
                ac  = (e.inst == 0) ? coll_f : coll_s;
                vectors += 3;
                if (ard !== e.rd) begin
                    fails++;
                    $display("FAIL rd_data inst%0d step %0d: got %h, want %h",
                             e.inst, e.step, ard, e.rd);
                end
                if (ab !== e.busy) begin
                    fails++;
                    $display("FAIL busy inst%0d step %0d: got %b, want %b",
                             e.inst, e.step, ab, e.busy);
                end
                if (ac !== e.coll) begin
                    fails++;
                    $display("FAIL collision inst%0d step %0d: got %b, want %b",
                             e.inst, e.step, ac, e.coll);
                end
            end
        end
    end

    initial begin : stimulus
        @(posedge clk);
        #1;
        // Reset values.
        do_idle(2);
        reset = 0;
        do_idle(1);

        // Preload, then full clear with clr_mem held; writes/preloads during sweep dropped.
        do_init(12'h000, 32'h1111_1111);
        do_init(12'h7FF, 32'h2222_2222);
        do_init(12'hFFF, 32'h3333_3333);
        clr_in(); clr_mem = 1; step();
        clr_in(); clr_mem = 1; step();
        do_write(12'h010, 32'hBAD0_BAD0);
        do_read(12'h000);
        do_idle(20);
        do_init(12'h005, 32'hFFFF_0000);
        do_idle(4100);
        do_read(12'h000);
        do_read(12'h7FF);
        do_read(12'hFFF);
        do_read(12'h010);
        do_read(12'h005);

        // Preload then read; write then read back; unwritten word reads 0.
        do_init(12'h010, 32'h1234_5678);
        do_read(12'h010);
        do_write(12'h0FF, 32'hDEAD_BEEF);
        do_read(12'h0FF);
        do_read(12'h100);

        // Collision and read-before-write with a same-edge preload.
        clr_in(); init_en = 1; init_addr = 12'h020; init_data = 32'hAAAA_AAAA;
        mem_en = 1; read_write = 1; address = 12'h020; wr_data = 32'h5555_5555; step();
        do_read(12'h020);
        clr_in(); init_en = 1; init_addr = 12'h003; init_data = 32'h0000_0077;
        mem_en = 1; read_write = 0; address = 12'h003; step();
        do_idle(2);
        do_read(12'h003);

        // Out of range for the small instance.
        do_write(12'h020, 32'h0000_0003);
        do_read(12'h020);

        // Reset in the middle of a sweep.
        for (int i = 0; i < 16; i++) do_init(12'(i), 32'h1);
        clr_in(); clr_mem = 1; step();
        do_idle(5);
        clr_in(); reset = 1; step();
        reset = 0;
        for (int i = 0; i < 16; i++) do_read(12'(i));

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            clr_in();
            reset      = ($urandom_range(0, 199) == 0);
            mem_en     = $urandom_range(0, 3) != 0;
            read_write = $urandom_range(0, 1) == 1;
            address    = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 40));
            wr_data    = $urandom;
            init_en    = $urandom_range(0, 3) == 0;
            init_addr  = ($urandom_range(0, 1) == 0) ? address : 12'($urandom_range(0, 40));
            init_data  = $urandom;
            clr_mem    = $urandom_range(0, 299) == 0;
            step();
        end
        reset = 0;
        do_idle(2);
        @(posedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
